// File: rtl/harmonic_mixer.sv
// rtl/harmonic_mixer.sv - time-multiplexed weighted harmonic mixer
// One signed MAC per clock over N_CH channels, then arithmetic shift and saturation.
module harmonic_mixer #(
  parameter int N_CH      = 8,
  parameter int SAMPLE_W  = 16,
  parameter int COEF_W    = 8,
  parameter int OUT_SHIFT = COEF_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_valid,
  input  logic [N_CH*SAMPLE_W-1:0]   s_in,
  input  logic                       coef_we,
  input  logic [$clog2(N_CH)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  output logic [SAMPLE_W-1:0]        sample_out,
  output logic                       sample_out_valid,
  output logic                       clip,
  output logic                       busy,
  output logic                       overrun
);
  localparam int CH_W   = $clog2(N_CH);
  localparam int PROD_W = SAMPLE_W + COEF_W + 1;
  localparam int ACC_W  = PROD_W + CH_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [1:0]                  state_q, state_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic signed [SAMPLE_W-1:0]  s_lat_q [N_CH];
  logic signed [SAMPLE_W-1:0]  s_lat_d [N_CH];
  logic [COEF_W-1:0]           shadow_q [N_CH];
  logic [COEF_W-1:0]           shadow_d [N_CH];
  logic [COEF_W-1:0]           active_q [N_CH];
  logic [COEF_W-1:0]           active_d [N_CH];
  logic [SAMPLE_W-1:0]         out_q, out_d;
  logic                        valid_q, valid_d;
  logic                        clip_q, clip_d;
  logic                        overrun_q, overrun_d;

  logic signed [SAMPLE_W-1:0]  s_cur;
  logic signed [COEF_W:0]      w_cur;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     acc_sum;
  logic signed [ACC_W-1:0]     shifted;
  logic [SAMPLE_W-1:0]         sat_val;
  logic                        sat_clip;

  // The final product is folded in combinationally so the result lands as DONE begins.
  always_comb begin
    s_cur   = s_lat_q[ch_q];
    w_cur   = $signed({1'b0, active_q[ch_q]});
    prod    = PROD_W'(s_cur) * PROD_W'(w_cur);
    acc_sum = acc_q + ACC_W'(prod);
    shifted = acc_sum >>> OUT_SHIFT;
    sat_val  = shifted[SAMPLE_W-1:0];
    sat_clip = 1'b0;
    if (shifted > SAT_MAX) begin
      sat_val  = {1'b0, {(SAMPLE_W-1){1'b1}}};
      sat_clip = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val  = {1'b1, {(SAMPLE_W-1){1'b0}}};
      sat_clip = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ch_d      = ch_q;
    s_lat_d   = s_lat_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    out_d     = out_q;
    clip_d    = clip_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (sample_valid && (state_q != IDLE));
    if (coef_we && (32'(coef_addr) < N_CH)) begin
      shadow_d[coef_addr] = coef_data;
    end
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          for (int k = 0; k < N_CH; k++) begin
            s_lat_d[k] = s_in[k*SAMPLE_W +: SAMPLE_W];
          end
          // shadow_d already carries a same-cycle weight write.
          active_d = shadow_d;
          acc_d    = '0;
          ch_d     = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        ch_d  = ch_q + 1'b1;
        if (ch_q == CH_W'(N_CH-1)) begin
          ch_d    = '0;
          out_d   = sat_val;
          clip_d  = sat_clip;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      ch_q      <= '0;
      out_q     <= '0;
      clip_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        s_lat_q[k]  <= '0;
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ch_q      <= ch_d;
      out_q     <= out_d;
      clip_q    <= clip_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      s_lat_q   <= s_lat_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  assign sample_out       = out_q;
  assign sample_out_valid = valid_q;
  assign clip             = clip_q;
  assign busy             = (state_q != IDLE);
  assign overrun          = overrun_q;

endmodule
